// File: rtl/fir32_ctrl.sv
// fir32_ctrl
// ----------
// Sequencer for the 32-tap matched-filter FIR of the 802.11b receiver.
// Samples from the decimator arrive over a valid/ready handshake. Each one is
// presented to the FIR as a one-cycle strobe, followed by GAP compute cycles.
// The FIR delay line has no reset, so the block clocks TAPS zero samples
// through it after reset and on every flush request. It also tracks pipeline
// warm-up and forwards filtered results with a one-cycle out_valid pulse.
//
// Optional feature: define FIR32_CTRL_RATE_CHECK_EN to add the input-rate
// checker behind rate_err. Without the macro, rate_err is tied to 0.
//
// Ports
//   clk         system clock (64 MHz for 32 MSps)
//   reset       asynchronous reset, active low
//   in_data     sample from the decimator
//   in_valid    in_data is valid
//   in_ready    controller accepts in_data this cycle
//   flush       synchronous request to zero the FIR delay line
//   fir_data    to FIR indata
//   fir_strobe  to FIR strobe_in
//   fir_result  from FIR data_conv
//   out_data    filtered sample
//   out_valid   one-cycle pulse, out_data is valid
//   busy        flush in progress
//   rate_err    sticky input-rate violation
module fir32_ctrl #(
   parameter int TAPS     = 32,
   parameter int GAP      = 1,
   parameter int PIPE_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [15:0] fir_data,
   output logic        fir_strobe,
   input  logic [15:0] fir_result,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        busy,
   output logic        rate_err
);

   localparam int SW = $clog2(TAPS + PIPE_LAT + 1);
   localparam int ZW = $clog2(TAPS + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [SW-1:0] SCNT_MAX = SW'(TAPS + PIPE_LAT);
   localparam logic [ZW-1:0] ZCNT_END = ZW'(TAPS);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMP,
      FLUSH_LOAD,
      FLUSH_COMP
   } state_t;

   state_t        state, state_next;
   logic [GW-1:0] gcnt, gcnt_next;
   logic [ZW-1:0] zcnt, zcnt_next;
   logic [SW-1:0] scnt, scnt_next;
   logic          armed;
   logic          start_flush;
   logic          xfer;
   logic          gap_done;
   logic          capture;
   logic          ready_next;

   // Next-state logic. A flush request (or the automatic flush armed by reset)
   // overrides everything: any accepted-but-unloaded sample is dropped, while a
   // strobe already on the wire has been seen by the FIR and simply completes.
   // zcnt counts zero strobes issued, including the one being entered.
   // The output capture happens in the first compute cycle after a load, once
   // enough strobes have gone through for the FIR output to be meaningful.
   always_comb begin
      start_flush = flush || armed;
      xfer        = in_valid && in_ready;
      gap_done    = (gcnt == GAP_LAST);
      capture     = 1'b0;
      state_next  = state;
      gcnt_next   = gcnt;
      zcnt_next   = zcnt;
      scnt_next   = scnt;

      if (start_flush) begin
         state_next = FLUSH_LOAD;
         zcnt_next  = ZW'(1);
         scnt_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) state_next = LOAD;
            end
            LOAD: begin
               state_next = COMP;
               gcnt_next  = '0;
            end
            COMP: begin
               if ((gcnt == '0) && (scnt >= SCNT_MAX)) capture = 1'b1;
               if (gap_done) state_next = xfer ? LOAD : IDLE;
               else          gcnt_next  = gcnt + GW'(1);
            end
            FLUSH_LOAD: begin
               state_next = FLUSH_COMP;
               gcnt_next  = '0;
            end
            FLUSH_COMP: begin
               if (gap_done) begin
                  if (zcnt == ZCNT_END) begin
                     state_next = IDLE;
                     scnt_next  = '0;
                  end else begin
                     state_next = FLUSH_LOAD;
                     zcnt_next  = zcnt + ZW'(1);
                  end
               end else begin
                  gcnt_next = gcnt + GW'(1);
               end
            end
            default: begin
               state_next = FLUSH_LOAD;
               zcnt_next  = ZW'(1);
               scnt_next  = '0;
            end
         endcase
      end

      if ((state_next == LOAD) && (scnt != SCNT_MAX)) scnt_next = scnt + SW'(1);

      ready_next = (state_next == IDLE) ||
                   ((state_next == COMP) && (gcnt_next == GAP_LAST));
   end

   // State and registered outputs. Outputs are computed from the state being
   // entered so they line up with the state itself. Reset leaves the machine
   // armed with all outputs low; the first edge after release starts the
   // mandatory zero flush, because the FIR tap memory powers up undefined.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FLUSH_LOAD;
         armed      <= 1'b1;
         gcnt       <= '0;
         zcnt       <= '0;
         scnt       <= '0;
         in_ready   <= 1'b0;
         fir_data   <= '0;
         fir_strobe <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         armed      <= 1'b0;
         gcnt       <= gcnt_next;
         zcnt       <= zcnt_next;
         scnt       <= scnt_next;
         in_ready   <= ready_next;
         fir_strobe <= (state_next == LOAD) || (state_next == FLUSH_LOAD);
         busy       <= (state_next == FLUSH_LOAD) || (state_next == FLUSH_COMP);
         out_valid  <= capture;
         if (state_next == LOAD)            fir_data <= in_data;
         else if (state_next == FLUSH_LOAD) fir_data <= '0;
         if (capture) out_data <= fir_result;
      end
   end

`ifdef FIR32_CTRL_RATE_CHECK_EN
   localparam int RW = $clog2(GAP + 3);
   localparam logic [RW-1:0] RATE_OK  = RW'(GAP + 1);
   localparam logic [RW-1:0] RATE_SAT = RW'(GAP + 2);

   logic [RW-1:0] rcnt;
   logic          have_prev;

   // Input-rate checker. rcnt counts cycles since the previous accepted
   // transfer and saturates just above the legal spacing so long pauses still
   // read as a violation. A flush forgets the previous transfer, so the first
   // sample after it is never judged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt      <= '0;
         have_prev <= 1'b0;
         rate_err  <= 1'b0;
      end else if (start_flush) begin
         have_prev <= 1'b0;
      end else if (xfer) begin
         if (have_prev && (rcnt != RATE_OK)) rate_err <= 1'b1;
         have_prev <= 1'b1;
         rcnt      <= RW'(1);
      end else if (rcnt != RATE_SAT) begin
         rcnt <= rcnt + RW'(1);
      end
   end
`else
   assign rate_err = 1'b0;
`endif

endmodule

// File: doc/fir32_ctrl.md
# fir32_ctrl

Sequencer for the 32-tap 32 MSps matched-filter datapath in the 802.11b receiver. It accepts samples from the decimator over a valid/ready handshake and drives the FIR's `indata`/`strobe_in` pair. Each strobe cycle is followed by the mandatory compute gap, and the block flushes the FIR's un-reset tap memory with zeros. It tracks pipeline warm-up and emits filtered samples with a one-cycle `out_valid` pulse to the despreader.

## Interface
- `TAPS`, 32: FIR delay-line length; sets zero-strobe count for flush and warm-up.
- `GAP`, 1: compute cycles after every strobe, ≥1; sample period = GAP+1 clocks.
- `PIPE_LAT`, 2: strobes from a sample's load until its result is in `data_conv`.
- `clk`  in  1  system clock (64 MHz for 32 MSps).
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  16  sample from decimator.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `flush`  in  1  synchronous request to zero the FIR delay line.
- `fir_data`  out  16  to FIR `indata`.
- `fir_strobe`  out  1  to FIR `strobe_in`.
- `fir_result`  in  16  from FIR `data_conv`.
- `out_data`  out  16  filtered sample.
- `out_valid`  out  1  one-cycle pulse, `out_data` valid.
- `busy`  out  1  flush in progress.
- `rate_err`  out  1  sticky input-rate violation (see Configuration).

## Operation
- States: IDLE, LOAD, COMP, FLUSH_LOAD, FLUSH_COMP.
- Handshake: a transfer occurs when `in_valid && in_ready`. `in_ready` = 1 in IDLE and in the last COMP cycle; 0 otherwise.
- On a transfer, `in_data` is registered and the next state is LOAD.
- LOAD: `fir_strobe`=1, `fir_data`=registered sample, 1 cycle, then COMP.
- COMP: `fir_strobe`=0 for GAP cycles. Exit: LOAD if a transfer occurs in the last COMP cycle, else IDLE.
- `fir_data` holds its last value whenever `fir_strobe`=0.
- Strobe counter `scnt` increments on each LOAD and saturates at TAPS+PIPE_LAT.
- Output: in the first COMP cycle after a LOAD, if `scnt` ≥ TAPS+PIPE_LAT (post-increment), `fir_result` is registered into `out_data`, and `out_valid`=1 in the following cycle.
- `out_data` holds between pulses.
- Flush: FLUSH_LOAD drives `fir_strobe`=1 with `fir_data`=0. FLUSH_COMP holds for GAP cycles. The pair repeats TAPS times, then IDLE with `scnt`=0.
- `busy`=1 and `in_ready`=0 throughout a flush; `out_valid` is suppressed.
- `flush`=1 in any state: the next state is FLUSH_LOAD with the zero count restarted at 0. A registered sample not yet loaded is discarded. A LOAD in the current cycle completes, since its edge is already taken.
- `flush` during a flush restarts the count.
- Arithmetic: no arithmetic on data; `scnt` is ⌈log2(TAPS+PIPE_LAT+1)⌉ bits.

## Timing
- Reset (asserted) values: all outputs 0, `scnt`=0, state FLUSH_LOAD armed.
- After `reset` releases, an automatic flush runs, because the FIR has no reset. `busy`=1 for TAPS×(GAP+1) cycles (64 at defaults), then `in_ready`=1.
- Throughput: one sample per GAP+1 clocks with `in_valid` held high.
- Latency: the `out_valid` pulse is 2 cycles after its triggering LOAD. That result corresponds to the sample loaded PIPE_LAT strobes earlier.
- Reset assertion mid-operation aborts immediately; the post-reset flush repeats.
- `in_valid` deasserted in the last COMP cycle leads to IDLE. There is no bubble penalty beyond the waiting time.

## Configuration
- `FIR32_CTRL_RATE_CHECK_EN` defined: a cycle counter measures the spacing between consecutive transfers outside flush.
  - Spacing ≠ GAP+1 sets `rate_err`, sticky until `reset`.
  - The first transfer after IDLE entry following a flush is not checked.
- Not defined: `rate_err` is tied to 0 and the counter is absent.

## Test plan
- Reset release, `in_valid`=0 → exactly 32 `fir_strobe` pulses with `fir_data`=0, each followed by 1 low cycle. `busy` is high 64 cycles, then `in_ready`=1.
- Continuous `in_valid`, samples 1,2,3… → `fir_strobe` alternates 1/0 and `fir_data` follows the sample sequence.
  - No `out_valid` for the first 33 loads.
  - First `out_valid` 2 cycles after the 34th LOAD; `out_data` equals the `fir_result` value present in the cycle after that LOAD.
- `in_valid` dropped for 5 cycles mid-stream → state returns to IDLE with no strobes. On resume, the first strobe comes 1 cycle after acceptance; `scnt` is retained.
- `flush` pulsed 1 cycle after a LOAD at sample 50 → the pending sample is dropped, 32 zero strobes follow, and `scnt`=0. The next 34 loads are needed before `out_valid`.
- `flush` asserted again at zero-strobe 10 → the count restarts and 32 further zero strobes follow.
- With `FIR32_CTRL_RATE_CHECK_EN`, transfers spaced 3 cycles apart → `rate_err`=1 after the second transfer and it stays 1. Without the macro, `rate_err`=0.
